// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer: packs a byte stream into two operands, hands them to the adder and
// streams the (WIDTH+1)-bit sum back out LSB first. ADDSEQ_TIMEOUT_EN adds a WAIT_SUM abort timer.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_LOAD_A   | collecting operand A bytes, little-endian
//   S_LOAD_B   | collecting operand B bytes, little-endian
//   S_ISSUE    | op_valid high, waiting for op_ready
//   S_WAIT_SUM | waiting for the sum_valid pulse (optionally time-limited)
//   S_DRAIN    | emitting result bytes, carry byte last
module adder_operand_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ena_i,
    input  logic [7:0]       din_i,
    input  logic             din_valid_i,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    input  logic [WIDTH:0]   sum_in_i,
    input  logic             sum_valid_i,
    output logic [7:0]       dout_o,
    output logic             dout_valid_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(NB + 2);
    localparam logic [CW-1:0] LAST_OP   = CW'(NB - 1);
    localparam logic [CW-1:0] CARRY_IDX = CW'(NB);
    localparam logic [CW-1:0] DRAIN_END = CW'(NB + 1);

    localparam logic [2:0] S_LOAD_A   = 3'd0;
    localparam logic [2:0] S_LOAD_B   = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_SUM = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    if (WIDTH < 8 || WIDTH > 32 || (WIDTH % 8) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("adder_operand_sequencer: unsupported WIDTH/TIMEOUT");
    end

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             op_valid_q, op_valid_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

`ifdef ADDSEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        res_d        = res_q;
        op_valid_d   = op_valid_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
`ifdef ADDSEQ_TIMEOUT_EN
        tmr_d        = tmr_q;
        err_d        = err_q;
`endif
        if (ena_i) begin
            case (state_q)
                S_LOAD_A: begin
                    if (din_valid_i) begin
                        for (int i = 0; i < NB; i++) begin
                            if (cnt_q == CW'(i)) op_a_d[8*i +: 8] = din_i;
                        end
                        if (cnt_q == LAST_OP) begin
                            cnt_d   = '0;
                            state_d = S_LOAD_B;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (din_valid_i) begin
                        for (int i = 0; i < NB; i++) begin
                            if (cnt_q == CW'(i)) op_b_d[8*i +: 8] = din_i;
                        end
                        if (cnt_q == LAST_OP) begin
                            cnt_d      = '0;
                            op_valid_d = 1'b1;
                            state_d    = S_ISSUE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_valid_q && op_ready_i) begin
                        op_valid_d = 1'b0;
                        state_d    = S_WAIT_SUM;
`ifdef ADDSEQ_TIMEOUT_EN
                        tmr_d      = TMR_LOAD;
`endif
                    end
                end
                S_WAIT_SUM: begin
                    // Byte 0 goes straight out with the capture so the first byte appears one cycle after sum_valid.
                    if (sum_valid_i) begin
                        res_d        = sum_in_i;
                        dout_d       = sum_in_i[7:0];
                        dout_valid_d = 1'b1;
                        cnt_d        = CW'(1);
                        state_d      = S_DRAIN;
                    end
`ifdef ADDSEQ_TIMEOUT_EN
                    else if (tmr_q == '0) begin
                        err_d   = 1'b1;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        state_d = S_LOAD_A;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_END) begin
                        dout_valid_d = 1'b0;
                        op_a_d       = '0;
                        op_b_d       = '0;
                        cnt_d        = '0;
                        state_d      = S_LOAD_A;
                    end else begin
                        if (cnt_q == CARRY_IDX) begin
                            dout_d = {7'b0, res_q[WIDTH]};
                        end else begin
                            for (int i = 0; i < NB; i++) begin
                                if (cnt_q == CW'(i)) dout_d = res_q[8*i +: 8];
                            end
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_LOAD_A;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
            op_valid_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
`ifdef ADDSEQ_TIMEOUT_EN
            tmr_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            res_q        <= res_d;
            op_valid_q   <= op_valid_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
`ifdef ADDSEQ_TIMEOUT_EN
            tmr_q        <= tmr_d;
            err_q        <= err_d;
`endif
        end
    end

    assign op_a_o       = op_a_q;
    assign op_b_o       = op_b_q;
    assign op_valid_o   = op_valid_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign busy_o       = !(state_q == S_LOAD_A && cnt_q == '0);
`ifdef ADDSEQ_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule
